// File: rtl/fp16_group_aligner.sv
// ---------------------------------------------------------------------------
// fp16_group_aligner
//
// Front end of the MAC accumulate path. Collects a group of GROUP FP16
// products into a local buffer while tracking the group's maximum exponent.
// It then streams out one signed 19-bit fixed-point term per product, each
// aligned to that shared exponent.
//
// Term layout (as consumed by the final normalizer):
//   bit 18    : sign (two's complement)
//   bit 13    : leading one when the element's exponent equals the max
//   bits 12:3 : mantissa
//   bits 2:0  : guard / round / sticky region
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_valid    input FP16 word valid
//   i_data     FP16 product {sign, exp[4:0], mant[9:0]}
//   o_ready    block accepts i_data this cycle (high while collecting)
//   o_valid    o_term valid (high while emitting)
//   i_ready    downstream accepts o_term
//   o_term     signed aligned term
//   o_max_exp  group maximum exponent, stable while emitting
//   o_last     marks the final term of a group
//   o_exc      group contained an Inf/NaN (exp == 31)
// ---------------------------------------------------------------------------
module fp16_group_aligner #(
    parameter int GROUP = 4,
    parameter int CNT_W = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [15:0] i_data,
    output logic        o_ready,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [18:0] o_term,
    output logic [4:0]  o_max_exp,
    output logic        o_last,
    output logic        o_exc
);

    // Narrowest index that addresses exactly GROUP buffer entries.
    localparam int IDX_W = (GROUP > 1) ? $clog2(GROUP) : 1;

    typedef enum logic {
        ST_COLLECT,
        ST_EMIT
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [15:0]      r_buf [GROUP];
    logic [CNT_W-1:0] r_idx;
    logic [4:0]       r_max_exp;
    logic             r_exc;

    logic             w_accept;
    logic             w_emit_hs;
    logic             w_is_last;
    logic [4:0]       w_in_exp;
    logic             w_in_normal;

    logic [15:0]      w_elem;
    logic             w_el_sign;
    logic [4:0]       w_el_exp;
    logic [9:0]       w_el_mant;
    logic             w_el_normal;
    logic [4:0]       w_shift;
    logic [18:0]      w_sig;
    logic [18:0]      w_lost_mask;
    logic [18:0]      w_shifted;
    logic             w_sticky;
    logic [18:0]      w_mag;
    logic [18:0]      w_term;

    assign w_accept    = (r_state == ST_COLLECT) && i_valid;
    assign w_emit_hs   = (r_state == ST_EMIT) && i_ready;
    assign w_is_last   = (r_idx == CNT_W'(GROUP - 1));
    assign w_in_exp    = i_data[14:10];
    assign w_in_normal = (w_in_exp != 5'd0) && (w_in_exp != 5'd31);

    // State register: the block alternates strictly between filling the
    // buffer and draining it, so there is never an accept and an emit in
    // the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: leave COLLECT on the GROUP-th accepted word, leave EMIT
    // on the handshake of the last term.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_COLLECT: if (w_accept && w_is_last)  w_next_state = ST_EMIT;
            ST_EMIT:    if (w_emit_hs && w_is_last) w_next_state = ST_COLLECT;
            default:    w_next_state = ST_COLLECT;
        endcase
    end

    // Element index, running max exponent and exception flag. The max
    // update folds in the word accepted on the final collect cycle, so the
    // first emitted term already sees the complete group maximum. Specials
    // (zero/subnormal and Inf/NaN) never contribute to the maximum.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx     <= '0;
            r_max_exp <= 5'd0;
            r_exc     <= 1'b0;
        end else if (w_accept) begin
            r_idx <= w_is_last ? '0 : r_idx + 1'b1;
            if (w_in_normal && (w_in_exp > r_max_exp)) begin
                r_max_exp <= w_in_exp;
            end
            if (w_in_exp == 5'd31) begin
                r_exc <= 1'b1;
            end
        end else if (w_emit_hs) begin
            if (w_is_last) begin
                r_idx     <= '0;
                r_max_exp <= 5'd0;
                r_exc     <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Group buffer. Contents are don't-care after reset because nothing is
    // read until a full group has been written, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_buf[r_idx[IDX_W-1:0]] <= i_data;
        end
    end

    assign w_elem      = r_buf[r_idx[IDX_W-1:0]];
    assign w_el_sign   = w_elem[15];
    assign w_el_exp    = w_elem[14:10];
    assign w_el_mant   = w_elem[9:0];
    assign w_el_normal = (w_el_exp != 5'd0) && (w_el_exp != 5'd31);

    // The max never falls below any normal element's exponent, so this
    // difference cannot wrap for the elements that use it.
    assign w_shift     = r_max_exp - w_el_exp;
    assign w_sig       = {5'b0, 1'b1, w_el_mant, 3'b0};
    assign w_lost_mask = (19'd1 << w_shift) - 19'd1;
    assign w_shifted   = w_sig >> w_shift;
    assign w_sticky    = |(w_sig & w_lost_mask);

    // Alignment of the current element. From a shift of 14 upward the
    // whole significand lands below bit 0, leaving only the sticky bit.
    always_comb begin
        w_mag = 19'd0;
        if (w_el_normal) begin
            if (w_shift >= 5'd14) begin
                w_mag = 19'd1;
            end else begin
                w_mag = w_shifted | {18'b0, w_sticky};
            end
        end
        w_term = w_el_sign ? (19'd0 - w_mag) : w_mag;
    end

    assign o_ready   = (r_state == ST_COLLECT);
    assign o_valid   = (r_state == ST_EMIT);
    assign o_term    = (r_state == ST_EMIT) ? w_term : 19'd0;
    assign o_max_exp = r_max_exp;
    assign o_last    = (r_state == ST_EMIT) && w_is_last;
    assign o_exc     = (r_state == ST_EMIT) && r_exc;

endmodule

// File: tb/tb_fp16_group_aligner.sv
// ---------------------------------------------------------------------------
// tb_fp16_group_aligner
//
// Directed and randomized checks of fp16_group_aligner. Expected terms come
// from an arithmetic reference: the significand scaled by 8 is divided by
// 2^(max_exp - exp), and a non-zero remainder sets bit 0.
// ---------------------------------------------------------------------------
module tb_fp16_group_aligner;

    localparam int GROUP = 4;
    localparam int CNT_W = 4;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic [15:0] i_data;
    logic        o_ready;
    logic        o_valid;
    logic        i_ready;
    logic [18:0] o_term;
    logic [4:0]  o_max_exp;
    logic        o_last;
    logic        o_exc;

    int total;
    int bad;

    logic [15:0] gWords  [GROUP];
    logic [18:0] expTerm [GROUP];
    int          expMax;
    logic        expExc;

    fp16_group_aligner #(
        .GROUP (GROUP),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_term    (o_term),
        .o_max_exp (o_max_exp),
        .o_last    (o_last),
        .o_exc     (o_exc)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // One comparison: counts it, and on mismatch counts the failure.
    task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference alignment of one FP16 word against a group exponent.
    function automatic logic [18:0] alignModel(input logic [15:0] w, input int maxe);
        int     e;
        int     d;
        longint scaled;
        longint divisor;
        longint q;
        longint r;
        longint v;
        e = int'(w[14:10]);
        if (e == 0 || e == 31) return 19'd0;
        d       = maxe - e;
        scaled  = longint'({1'b1, w[9:0]}) * 8;
        divisor = longint'(1) << d;
        q       = scaled / divisor;
        r       = scaled % divisor;
        if (r != 0) q = q | 1;
        v = w[15] ? ((524288 - q) % 524288) : q;
        return v[18:0];
    endfunction

    // Reference for the whole group currently in gWords.
    task automatic buildExpected();
        int e;
        expMax = 0;
        expExc = 1'b0;
        for (int k = 0; k < GROUP; k++) begin
            e = int'(gWords[k][14:10]);
            if (e == 31) expExc = 1'b1;
            else if (e != 0 && e > expMax) expMax = e;
        end
        for (int k = 0; k < GROUP; k++) expTerm[k] = alignModel(gWords[k], expMax);
    endtask

    // Feeds the first n words of gWords, one per cycle. Called and
    // returns just after a rising edge.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            i_valid = 1'b1;
            i_data  = gWords[k];
            chk("collect_ready", 19'(o_ready), 19'd1);
            chk("collect_valid", 19'(o_valid), 19'd0);
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        i_data  = 16'h0000;
    endtask

    // Drains one group and checks every presented term. The ready pattern
    // either stalls term stallIdx for stallLen cycles or is random.
    task automatic checkOutput(input int stallIdx, input int stallLen, input bit rndReady);
        int   k;
        int   stall;
        int   cycles;
        logic r;
        buildExpected();
        k      = 0;
        stall  = 0;
        cycles = 0;
        while (k < GROUP && cycles < 64) begin
            if (rndReady) begin
                r = ($urandom_range(0, 3) != 0);
            end else if (k == stallIdx && stall < stallLen) begin
                r = 1'b0;
                stall++;
            end else begin
                r = 1'b1;
            end
            i_ready = r;
            chk("emit_valid",   19'(o_valid),   19'd1);
            chk("emit_ready",   19'(o_ready),   19'd0);
            chk("term",         o_term,         expTerm[k]);
            chk("last",         19'(o_last),    19'(k == GROUP - 1));
            chk("max_exp",      19'(o_max_exp), 19'(expMax));
            chk("exc",          19'(o_exc),     19'(expExc));
            @(posedge i_clk);
            #1;
            if (r) k++;
            cycles++;
        end
        if (k < GROUP) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_budget: observed=%0d terms expected=%0d", k, GROUP);
        end
        i_ready = 1'b0;
        chk("post_valid", 19'(o_valid), 19'd0);
        chk("post_ready", 19'(o_ready), 19'd1);
    endtask

    task automatic setGroup(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        gWords[0] = a;
        gWords[1] = b;
        gWords[2] = c;
        gWords[3] = d;
    endtask

    // Random FP16 word: exponents clustered near base, with occasional
    // zero/subnormal and Inf/NaN encodings.
    function automatic logic [15:0] randWord(input int base);
        int          sel;
        logic [4:0]  e;
        logic [9:0]  m;
        logic        s;
        sel = int'($urandom_range(0, 15));
        s   = 1'($urandom_range(0, 1));
        m   = 10'($urandom_range(0, 1023));
        if (sel == 0)      e = 5'd0;
        else if (sel == 1) e = 5'd31;
        else if (sel == 2) e = 5'($urandom_range(1, 30));
        else               e = 5'(base + int'($urandom_range(0, 6)));
        return {s, e, m};
    endfunction

    initial begin
        total   = 0;
        bad     = 0;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_data  = 16'h0000;
        i_ready = 1'b0;

        repeat (2) @(posedge i_clk);
        #1;
        $display("[TB] reset state");
        chk("rst_ready",   19'(o_ready),   19'd1);
        chk("rst_valid",   19'(o_valid),   19'd0);
        chk("rst_term",    o_term,         19'd0);
        chk("rst_max_exp", 19'(o_max_exp), 19'd0);
        chk("rst_last",    19'(o_last),    19'd0);
        chk("rst_exc",     19'(o_exc),     19'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        $display("[TB] basic group");
        setGroup(16'h3C00, 16'h4000, 16'hBC00, 16'h0000);
        applyStimulus(GROUP);
        chk("s1_max_exp_const", 19'(o_max_exp), 19'd16);
        chk("s1_term0_const",   o_term,         19'h01000);
        checkOutput(-1, 0, 1'b0);

        $display("[TB] sticky group");
        setGroup(16'h5000, 16'h3C01, 16'h5000, 16'h5000);
        applyStimulus(GROUP);
        checkOutput(-1, 0, 1'b0);

        $display("[TB] large shift group");
        setGroup(16'h7800, 16'h0400, 16'h8400, 16'h7800);
        applyStimulus(GROUP);
        chk("s3_max_exp_const", 19'(o_max_exp), 19'd30);
        checkOutput(-1, 0, 1'b0);

        $display("[TB] backpressure on second term");
        setGroup(16'h3C00, 16'h4000, 16'hBC00, 16'h0000);
        applyStimulus(GROUP);
        checkOutput(1, 3, 1'b0);

        $display("[TB] exception group then clean group");
        setGroup(16'h3C00, 16'h7C00, 16'h4000, 16'hBC00);
        applyStimulus(GROUP);
        checkOutput(-1, 0, 1'b0);
        setGroup(16'h3800, 16'h3800, 16'h3400, 16'h3C00);
        applyStimulus(GROUP);
        chk("s5_max_exp_const", 19'(o_max_exp), 19'd15);
        checkOutput(-1, 0, 1'b0);

        $display("[TB] all-special group");
        setGroup(16'h0000, 16'h8000, 16'h03FF, 16'h8001);
        applyStimulus(GROUP);
        checkOutput(-1, 0, 1'b0);

        $display("[TB] reset mid-collect");
        setGroup(16'h7800, 16'h7C00, 16'h0000, 16'h0000);
        applyStimulus(2);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_ready",   19'(o_ready),   19'd1);
        chk("midrst_valid",   19'(o_valid),   19'd0);
        chk("midrst_max_exp", 19'(o_max_exp), 19'd0);
        #2;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        setGroup(16'h3C00, 16'h4000, 16'hBC00, 16'h0000);
        applyStimulus(GROUP);
        checkOutput(-1, 0, 1'b0);

        $display("[TB] reset mid-emit");
        applyStimulus(GROUP);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("emitrst_valid", 19'(o_valid), 19'd0);
        chk("emitrst_ready", 19'(o_ready), 19'd1);
        chk("emitrst_term",  o_term,       19'd0);
        chk("emitrst_last",  19'(o_last),  19'd0);
        #2;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        setGroup(16'h5000, 16'h3C01, 16'h5000, 16'h5000);
        applyStimulus(GROUP);
        checkOutput(-1, 0, 1'b0);

        $display("[TB] randomized groups");
        for (int g = 0; g < 40; g++) begin
            int base;
            base = int'($urandom_range(1, 24));
            for (int k = 0; k < GROUP; k++) gWords[k] = randWord(base);
            applyStimulus(GROUP);
            checkOutput(-1, 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
